dmem_access_unit: RTL and testbench

- Memory-stage load/store engine between the pipelined datapath's EX/MEM outputs and a multi-cycle data RAM.
- Stores: generates byte-lane strobes and lane-replicated write data.
- Loads: extracts and sign- or zero-extends the addressed byte or halfword.
- Holds the pipeline with a stall signal until the RAM acknowledges; rejects misaligned accesses without touching memory.

---
 rtl/dmem_access_unit_if.sv | 38 +++
 rtl/dmem_access_unit.sv | 203 ++++++++++++++++++++
 tb/tb_dmem_access_unit.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_access_unit_if.sv
// Pipeline-side request/response and RAM-side bus of the memory-stage load/store unit.
// master = pipeline + RAM environment, slave = the load/store unit.
interface dmem_access_unit_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              stall;
  logic [31:0]       load_data;
  logic              load_valid;
  logic              misalign;
  logic              bus_err;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output mem_ack, mem_rdata,
    input  stall, load_data, load_valid, misalign, bus_err,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  mem_ack, mem_rdata,
    output stall, load_data, load_valid, misalign, bus_err,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/dmem_access_unit.sv
// Memory-stage load/store engine: store lane strobes/replication, load lane extract + extension.
// Optional RAM ack timeout abort is enabled by defining DMEM_ACK_TIMEOUT_EN.
module dmem_access_unit #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  dmem_access_unit_if.slave bus
);
  // state  | meaning
  // S_IDLE | sample request; aligned -> launch RAM access, misaligned -> reject
  // S_WAIT | RAM access outstanding, pipeline stalled, mem_* held
  // S_DONE | access retired, pipeline advances, load_valid for loads
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [3:0]        r_mem_be;
  logic [31:0]       r_mem_wdata;
  logic [31:0]       r_load_data;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [1:0]        r_addr_lo;

  logic              w_aligned;
  logic              w_stall;
  logic              w_misalign;
  logic              w_load_valid;
  logic              w_launch;
  logic              w_complete;
  logic              w_abort;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_fmt;

  if (TIMEOUT < 1) begin : g_timeout_check
    $error("dmem_access_unit: TIMEOUT must be at least 1");
  end

`ifdef DMEM_ACK_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0]  r_wait_cnt;
  logic              r_bus_err;
`endif

  always_comb begin
    w_aligned = 1'b1;
    case (bus.req_size)
      2'b00:   w_aligned = 1'b1;
      2'b01:   w_aligned = ~bus.req_addr[0];
      default: w_aligned = (bus.req_addr[1:0] == 2'b00);
    endcase
  end

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = bus.req_wdata;
    case (bus.req_size)
      2'b00: begin
        w_be    = 4'b0001 << bus.req_addr[1:0];
        w_wdata = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{bus.req_wdata[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = bus.req_wdata;
      end
    endcase
  end

  // Lane selection uses the latched request, since req_* may already show the next instruction.
  always_comb begin
    w_byte = bus.mem_rdata[7:0];
    case (r_addr_lo)
      2'd1:    w_byte = bus.mem_rdata[15:8];
      2'd2:    w_byte = bus.mem_rdata[23:16];
      2'd3:    w_byte = bus.mem_rdata[31:24];
      default: w_byte = bus.mem_rdata[7:0];
    endcase
    w_half = r_addr_lo[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (r_size)
      2'b00:   w_fmt = {{24{w_byte[7] & ~r_unsigned}}, w_byte};
      2'b01:   w_fmt = {{16{w_half[15] & ~r_unsigned}}, w_half};
      default: w_fmt = bus.mem_rdata;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_stall      = 1'b0;
    w_misalign   = 1'b0;
    w_load_valid = 1'b0;
    w_launch     = 1'b0;
    w_complete   = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (w_aligned) begin
            w_stall     = 1'b1;
            w_launch    = 1'b1;
            w_state_nxt = S_WAIT;
          end else begin
            w_misalign  = 1'b1;
          end
        end
      end
      S_WAIT: begin
        w_stall = 1'b1;
        if (bus.mem_ack) begin
          w_complete  = 1'b1;
          w_state_nxt = S_DONE;
        end
`ifdef DMEM_ACK_TIMEOUT_EN
        // This cycle is the TIMEOUT-th WAIT cycle without an ack.
        else if (r_wait_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_abort     = 1'b1;
          w_state_nxt = S_DONE;
        end
`endif
      end
      S_DONE: begin
        w_load_valid = ~r_mem_we;
        w_state_nxt  = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_be    <= 4'b0000;
      r_mem_wdata <= 32'h0;
      r_load_data <= 32'h0;
      r_size      <= 2'b00;
      r_unsigned  <= 1'b0;
      r_addr_lo   <= 2'b00;
    end else begin
      if (w_launch) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= bus.req_write;
        r_mem_addr  <= {bus.req_addr[ADDR_W-1:2], 2'b00};
        r_mem_be    <= w_be;
        r_mem_wdata <= w_wdata;
        r_size      <= bus.req_size;
        r_unsigned  <= bus.req_unsigned;
        r_addr_lo   <= bus.req_addr[1:0];
      end
      if (w_complete || w_abort) r_mem_req <= 1'b0;
      if (w_complete && !r_mem_we) r_load_data <= w_fmt;
      if (w_abort) r_load_data <= 32'h0;
    end
  end

`ifdef DMEM_ACK_TIMEOUT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wait_cnt <= '0;
      r_bus_err  <= 1'b0;
    end else begin
      if (w_launch)
        r_wait_cnt <= '0;
      else if (r_state == S_WAIT && !bus.mem_ack)
        r_wait_cnt <= r_wait_cnt + 1'b1;
      r_bus_err <= w_abort;
    end
  end
  assign bus.bus_err = r_bus_err;
`else
  assign bus.bus_err = 1'b0;
`endif

  assign bus.stall      = w_stall;
  assign bus.misalign   = w_misalign;
  assign bus.load_valid = w_load_valid;
  assign bus.load_data  = r_load_data;
  assign bus.mem_req    = r_mem_req;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_be     = r_mem_be;
  assign bus.mem_wdata  = r_mem_wdata;
endmodule

// File: tb/tb_dmem_access_unit.sv
// Scoreboard bench for dmem_access_unit: driver queues expected events, negedge monitor checks them.
module tb_dmem_access_unit;
`ifdef DMEM_ACK_TIMEOUT_EN
  localparam int TB_TIMEOUT = 4;
`else
  localparam int TB_TIMEOUT = 255;
`endif
  localparam int K_MEM  = 0;
  localparam int K_LD   = 1;
  localparam int K_MIS  = 2;
  localparam int K_BERR = 3;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
    logic        we;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  int   stall_q[$];
  int   run = 0;
  logic prev_req = 1'b0;

  dmem_access_unit_if #(.ADDR_W(32)) bus ();

  dmem_access_unit #(.ADDR_W(32), .TIMEOUT(TB_TIMEOUT)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic observe(input int k);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event: kind %0d seen, none expected", k);
    end else begin
      e = sb.pop_front();
      chk("event_kind", 32'(k), 32'(e.kind));
      if (k == K_MEM) begin
        chk("mem_addr", bus.mem_addr, e.addr);
        chk("mem_be", {28'h0, bus.mem_be}, {28'h0, e.be});
        chk("mem_wdata", bus.mem_wdata, e.data);
        chk("mem_we", {31'h0, bus.mem_we}, {31'h0, e.we});
      end else if (k == K_LD) begin
        chk("load_data", bus.load_data, e.data);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        run = 0;
        prev_req = 1'b0;
      end else begin
        if (bus.mem_req && !prev_req) observe(K_MEM);
        if (bus.load_valid) observe(K_LD);
        if (bus.misalign) observe(K_MIS);
        if (bus.bus_err) observe(K_BERR);
        if (bus.stall) begin
          run++;
        end else if (run > 0) begin
          if (stall_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_stall: got %0d cycles expected none", run);
          end else begin
            chk("stall_cycles", 32'(run), 32'(stall_q.pop_front()));
          end
          run = 0;
        end
        prev_req = bus.mem_req;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic access(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                        input int ack_n, input logic [31:0] e_addr, input logic [3:0] e_be,
                        input logic [31:0] e_wd, input logic [31:0] e_ld);
    sb.push_back('{K_MEM, e_addr, e_be, e_wd, wr});
    if (!wr) sb.push_back('{K_LD, 32'h0, 4'h0, e_ld, 1'b0});
    stall_q.push_back(1 + ack_n);
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_size = sz;
    bus.req_unsigned = uns; bus.req_addr = addr; bus.req_wdata = wd;
    @(posedge clk); #1;
    repeat (ack_n - 1) begin
      @(posedge clk); #1;
    end
    bus.mem_ack = 1'b1; bus.mem_rdata = rd;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0; bus.req_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic misaligned(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                            input logic [31:0] ld_hold);
    sb.push_back('{K_MIS, 32'h0, 4'h0, 32'h0, 1'b0});
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_size = sz;
    bus.req_unsigned = 1'b0; bus.req_addr = addr; bus.req_wdata = 32'h55AA_55AA;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    chk("misalign_no_req", {31'h0, bus.mem_req}, 32'h0);
    chk("misalign_ld_hold", bus.load_data, ld_hold);
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
    #2;
    chk("rst_mem_req", {31'h0, bus.mem_req}, 32'h0);
    chk("rst_mem_we", {31'h0, bus.mem_we}, 32'h0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_be", {28'h0, bus.mem_be}, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk("rst_load_data", bus.load_data, 32'h0);
    chk("rst_pulses", {29'h0, bus.load_valid, bus.misalign, bus.bus_err}, 32'h0);
    #10 rst_n = 1'b1;

    // Store byte to lane 3, ack in first WAIT cycle
    access(1'b1, 2'b00, 1'b0, 32'h0000_0103, 32'h0000_00AB, 32'h0, 1,
           32'h0000_0100, 4'b1000, 32'hABAB_ABAB, 32'h0);
    chk("store_ld_hold", bus.load_data, 32'h0);
    // Signed half load, upper lane, ack in third WAIT cycle
    access(1'b0, 2'b01, 1'b0, 32'h0000_0202, 32'h0, 32'h8001_1234, 3,
           32'h0000_0200, 4'b1100, 32'h0, 32'hFFFF_8001);
    access(1'b0, 2'b00, 1'b1, 32'h0000_0201, 32'h0, 32'h0000_F000, 1,
           32'h0000_0200, 4'b0010, 32'h0, 32'h0000_00F0);
    access(1'b0, 2'b00, 1'b0, 32'h0000_0201, 32'h0, 32'h0000_F000, 2,
           32'h0000_0200, 4'b0010, 32'h0, 32'hFFFF_FFF0);
    misaligned(1'b0, 2'b10, 32'h0000_0102, 32'hFFFF_FFF0);
    access(1'b1, 2'b01, 1'b0, 32'h0000_0206, 32'h1234_CAFE, 32'h0, 2,
           32'h0000_0204, 4'b1100, 32'hCAFE_CAFE, 32'h0);
    access(1'b1, 2'b11, 1'b0, 32'h0000_0300, 32'hDEAD_BEEF, 32'h0, 1,
           32'h0000_0300, 4'b1111, 32'hDEAD_BEEF, 32'h0);
    access(1'b0, 2'b10, 1'b0, 32'h0000_0304, 32'h0, 32'h89AB_CDEF, 2,
           32'h0000_0304, 4'b1111, 32'h0, 32'h89AB_CDEF);
    access(1'b0, 2'b00, 1'b0, 32'h0000_0303, 32'h0, 32'h7F00_0000, 1,
           32'h0000_0300, 4'b1000, 32'h0, 32'h0000_007F);
    access(1'b0, 2'b01, 1'b1, 32'h0000_0200, 32'h0, 32'h0000_ABCD, 1,
           32'h0000_0200, 4'b0011, 32'h0, 32'h0000_ABCD);
    misaligned(1'b0, 2'b01, 32'h0000_0101, 32'h0000_ABCD);
    misaligned(1'b0, 2'b11, 32'h0000_0301, 32'h0000_ABCD);
    misaligned(1'b1, 2'b01, 32'h0000_0203, 32'h0000_ABCD);

`ifdef DMEM_ACK_TIMEOUT_EN
    sb.push_back('{K_MEM, 32'h0000_0400, 4'b1111, 32'h0, 1'b0});
    sb.push_back('{K_LD, 32'h0, 4'h0, 32'h0, 1'b0});
    sb.push_back('{K_BERR, 32'h0, 4'h0, 32'h0, 1'b0});
    stall_q.push_back(1 + TB_TIMEOUT);
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = 2'b10;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h0000_0400; bus.req_wdata = 32'h0;
    @(posedge clk); #1;
    repeat (TB_TIMEOUT) @(posedge clk);
    #1;
    chk("timeout_req_drop", {31'h0, bus.mem_req}, 32'h0);
    chk("timeout_stall_low", {31'h0, bus.stall}, 32'h0);
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
`endif

    // Reset in the middle of a WAIT: mem_req must fall without a clock edge
    sb.push_back('{K_MEM, 32'h0000_0100, 4'b1111, 32'h0, 1'b0});
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = 2'b10;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h0000_0100; bus.req_wdata = 32'h0;
    @(posedge clk); #1;
    @(posedge clk); #3;
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_drops_req", {31'h0, bus.mem_req}, 32'h0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_no_lv", {31'h0, bus.load_valid}, 32'h0);
    chk("post_rst_ld", bus.load_data, 32'h0);
    chk("post_rst_no_req", {31'h0, bus.mem_req}, 32'h0);

    @(posedge clk); #1;
    chk("sb_drained", 32'(sb.size()), 32'h0);
    chk("stall_q_drained", 32'(stall_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
